// File: rtl/forwarding_scoreboard.sv
// Hazard/forwarding unit: N-source, M-stage operand forwarding plus a load scoreboard,
// ID-stage stall generation, stall statistics and a stall watchdog.
module forwarding_scoreboard #(
  parameter int REG_ADDR_W    = 5,
  parameter int NUM_SRC       = 3,
  parameter int NUM_FWD       = 2,
  parameter int SEL_W         = 2,
  parameter int MAX_OUT       = 4,
  parameter int CNT_W         = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_fwd_en,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_id,
  input  logic [NUM_SRC-1:0]            i_src_vld_id,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_exe,
  input  logic [NUM_SRC-1:0]            i_src_vld_exe,
  input  logic [REG_ADDR_W-1:0]         i_dest_exe,
  input  logic                          i_wb_en_exe,
  input  logic                          i_mem_r_en_exe,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] i_dest_stg,
  input  logic [NUM_FWD-1:0]            i_wb_en_stg,
  input  logic                          i_ld_issue,
  input  logic [REG_ADDR_W-1:0]         i_ld_dest,
  input  logic                          i_ld_done,
  input  logic [REG_ADDR_W-1:0]         i_ld_done_dest,
  output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
  output logic                          o_hazard_stall,
  output logic                          o_sb_full,
  output logic                          o_stall_state,
  output logic [CNT_W-1:0]              o_stall_cnt,
  output logic [1:0]                    o_err
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int OUT_W    = $clog2(MAX_OUT + 1);
  localparam int TO_W     = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  logic [NUM_REGS-1:0] r_pending;
  logic [OUT_W-1:0]    r_outstanding;
  state_t              r_state;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [TO_W-1:0]     r_consec;
  logic [1:0]          r_err;

  logic [NUM_SRC-1:0]  w_src_hz;
  logic                w_hazard;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] w_exe_addr;
      logic [REG_ADDR_W-1:0] w_id_addr;
      logic [SEL_W-1:0]      w_sel;
      logic                  w_hz;

      assign w_exe_addr = i_src_exe[gi*REG_ADDR_W +: REG_ADDR_W];
      assign w_id_addr  = i_src_id[gi*REG_ADDR_W +: REG_ADDR_W];

      // Scan from the farthest stage down so the nearest matching stage wins.
      always_comb begin
        w_sel = '0;
        if (i_fwd_en && i_src_vld_exe[gi] && (w_exe_addr != '0)) begin
          for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_wb_en_stg[k] && (i_dest_stg[k*REG_ADDR_W +: REG_ADDR_W] == w_exe_addr))
              w_sel = SEL_W'(k + 1);
          end
        end
      end

      always_comb begin
        w_hz = 1'b0;
        if (i_src_vld_id[gi] && (w_id_addr != '0)) begin
          if (i_fwd_en) begin
            w_hz = i_mem_r_en_exe & i_wb_en_exe & (i_dest_exe == w_id_addr);
          end else begin
            w_hz = i_wb_en_exe & (i_dest_exe == w_id_addr);
            for (int k = 0; k < NUM_FWD; k++) begin
              if (i_wb_en_stg[k] && (i_dest_stg[k*REG_ADDR_W +: REG_ADDR_W] == w_id_addr))
                w_hz = 1'b1;
            end
          end
          if (r_pending[w_id_addr])
            w_hz = 1'b1;
        end
      end

      assign o_fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
      assign w_src_hz[gi] = w_hz;
    end
  endgenerate

  assign w_hazard = |w_src_hz;

  // Scoreboard: retire first, then issue, so a same-register retire+issue keeps the bit set.
  logic                w_done_ok;
  logic                w_issue_ok;
  logic                w_misuse;
  logic [NUM_REGS-1:0] w_pend_mid;
  logic [NUM_REGS-1:0] w_pending_next;
  logic [OUT_W-1:0]    w_out_mid;
  logic [OUT_W-1:0]    w_out_next;

  always_comb begin
    w_done_ok  = i_ld_done & r_pending[i_ld_done_dest];
    w_pend_mid = r_pending;
    if (w_done_ok)
      w_pend_mid[i_ld_done_dest] = 1'b0;
    w_out_mid  = r_outstanding - OUT_W'(w_done_ok);
    w_issue_ok = i_ld_issue && (i_ld_dest != '0) && !w_pend_mid[i_ld_dest]
                 && (w_out_mid < OUT_W'(MAX_OUT));
    w_pending_next = w_pend_mid;
    if (w_issue_ok)
      w_pending_next[i_ld_dest] = 1'b1;
    w_out_next = w_out_mid + OUT_W'(w_issue_ok);
    w_misuse   = (i_ld_issue && (i_ld_dest != '0) && !w_issue_ok) || (i_ld_done && !w_done_ok);
  end

  state_t           w_state_next;
  logic [TO_W-1:0]  w_consec_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_hazard)  w_state_next = ST_STALL;
      ST_STALL: if (!w_hazard) w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_consec_next = '0;
    if (w_hazard)
      w_consec_next = (r_consec == TO_W'(STALL_TIMEOUT)) ? r_consec : r_consec + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_state       <= ST_RUN;
      r_stall_cnt   <= '0;
      r_consec      <= '0;
      r_err         <= '0;
    end else begin
      r_pending     <= w_pending_next;
      r_outstanding <= w_out_next;
      r_state       <= w_state_next;
      r_consec      <= w_consec_next;
      if (w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_misuse)
        r_err[0] <= 1'b1;
      if (w_hazard && (w_consec_next == TO_W'(STALL_TIMEOUT)))
        r_err[1] <= 1'b1;
    end
  end

  assign o_hazard_stall = w_hazard;
  assign o_sb_full      = (r_outstanding == OUT_W'(MAX_OUT));
  assign o_stall_state  = r_state;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_err          = r_err;

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised hazard and forwarding unit for the pipeline, generalising EXE-stage forwarding to N source operands and M forwarding stages. Adds a register-0 filter, per-source valid masks and a forwarding-disable mode. Adds a sequential scoreboard that tracks outstanding long-latency loads and generates the ID-stage stall. It also keeps stall statistics and a stall watchdog. Sits beside the ID/EXE pipeline registers and drives the EXE operand muxes and the PC/IF-ID freeze.

Parameters:
REG_ADDR_W, 5, register-file address width
NUM_SRC, 3, source operands per instruction (val1, val2, ST value)
NUM_FWD, 2, forwarding stages; index 0 = nearest (MEM), 1 = WB
SEL_W, 2, forwarding select width; must be >= clog2(NUM_FWD+1)
MAX_OUT, 4, maximum outstanding loads
CNT_W, 16, stall statistics counter width
STALL_TIMEOUT, 64, consecutive stall cycles before the watchdog fires

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
src_ID  in  NUM_SRC*REG_ADDR_W  ID-stage source addresses, packed, src k at [k*REG_ADDR_W +: REG_ADDR_W]
src_vld_ID  in  NUM_SRC  ID source valid mask
src_EXE  in  NUM_SRC*REG_ADDR_W  EXE-stage source addresses
src_vld_EXE  in  NUM_SRC  EXE source valid mask
dest_EXE  in  REG_ADDR_W  EXE destination
WB_EN_EXE  in  1  EXE instruction writes back
MEM_R_EN_EXE  in  1  EXE instruction is a load
dest_stg  in  NUM_FWD*REG_ADDR_W  destinations of the forwarding stages
WB_EN_stg  in  NUM_FWD  write-back enables of the forwarding stages
ld_issue  in  1  long-latency load accepted by memory this cycle
ld_dest  in  REG_ADDR_W  destination of the issued load
ld_done  in  1  long-latency load data returned this cycle
ld_done_dest  in  REG_ADDR_W  destination of the returning load
fwd_sel  out  NUM_SRC*SEL_W  per-source operand select; 0 = register file, k+1 = stage k
hazard_stall  out  1  freeze PC/IF-ID and bubble ID/EXE
sb_full  out  1  outstanding == MAX_OUT
stall_state  out  1  FSM state; 0 = RUN, 1 = STALL
stall_cnt  out  CNT_W  total stall cycles, saturating
err  out  2  sticky errors; [0] = scoreboard misuse, [1] = watchdog timeout

Behaviour:
- Reset (rst=0, asynchronous): pending bitmap = 0, outstanding = 0, FSM = RUN, stall_cnt = 0, consecutive counter = 0, err = 0.
- fwd_sel is combinational, zero latency. For each source with src_vld_EXE=1, fwd_en=1 and a nonzero address, choose the lowest stage index k where WB_EN_stg[k]=1 and dest_stg[k] equals the source. Drive k+1; if no stage matches, drive 0.
- fwd_sel is 0 when the source is invalid, the address is 0, or fwd_en=0.
- Register 0 never matches in any comparison.
- Hazard from ID source s (src_vld_ID=1, nonzero address) is combinational:
  - fwd_en=1: (MEM_R_EN_EXE & WB_EN_EXE & dest_EXE==s) | pending[s].
  - fwd_en=0: (WB_EN_EXE & dest_EXE==s) | any k (WB_EN_stg[k] & dest_stg[k]==s) | pending[s].
- hazard_stall = OR of the hazards over all ID sources.
- Scoreboard update, on the clock edge:
  - ld_issue with ld_dest≠0, pending[ld_dest]=0 and outstanding<MAX_OUT: set the bit, outstanding +1.
  - ld_issue when full, when already pending, or with ld_dest=0: ignored, err[0] set (except dest 0, which is silently ignored).
  - ld_done with pending[ld_done_dest]=1: clear the bit, outstanding −1.
  - ld_done to a non-pending register: ignored, err[0] set.
  - ld_issue and ld_done in the same cycle are both applied. For the same register, clear the old entry then set the new one: the bit stays 1 and outstanding is unchanged.
- sb_full = (outstanding == MAX_OUT), registered-state derived.
- FSM: RUN→STALL when hazard_stall=1 at the edge; STALL→RUN when hazard_stall=0. stall_state reflects the registered state, so it lags hazard_stall by one cycle.
- stall_cnt +1 on every edge with hazard_stall=1, saturating at all-ones.
- Consecutive counter +1 while hazard_stall=1 and cleared when it is 0. On reaching STALL_TIMEOUT, set err[1]. err bits clear only on reset.
- Reset asserted mid-stall drops hazard_stall on the next evaluation, because pending has cleared.

Test Plan:
- Forward priority: src_EXE={5,5,7}, all valid, dest_stg={5,5}, WB_EN_stg=2'b11 -> fwd_sel = {src0=1, src1=1, src2=0}. Drop WB_EN_stg[0] -> src0 and src1 = 2.
- Reg0/valid/mode: src=0 matching dest 0 -> sel 0. src_vld_EXE=0 -> sel 0. fwd_en=0 with ID src 3 and dest_stg[1]=3 -> sel 0 and hazard_stall=1.
- Load-use: MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=4, src_ID[1]=4 -> hazard_stall=1 same cycle, stall_state=1 next cycle, stall_cnt=1.
- Scoreboard: issue loads to r2, r3, r6, r9 -> sb_full=1. Fifth issue -> err[0]=1, outstanding stays 4. ld_done r3 together with ld_issue r3 -> pending r3 stays 1. ld_done r3 alone -> hazard on r3 clears.
- Watchdog/saturation: hold a pending match for 64 cycles -> err[1]=1 at cycle 64. With CNT_W=4, 20 stall cycles -> stall_cnt=15.
- Async reset mid-stall: rst low between edges -> all outputs reset immediately, hazard_stall=0 with no pending.
